// File: rtl/counter8_cmd_sched.sv
// Two-requester command scheduler driving the control pins of one counter8uni2.
// Build option: CNT_SCHED_FIXED_PRIO_EN selects fixed priority (req0 first) instead of round-robin.
module counter8_cmd_sched #(
    parameter int countWidth = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [1:0]            op0,
    input  logic [countWidth-1:0] data0,
    input  logic                  wrap0,
    input  logic                  req1,
    input  logic [1:0]            op1,
    input  logic [countWidth-1:0] data1,
    input  logic                  wrap1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [countWidth-1:0] done_value,
    output logic                  done_ovf,
    output logic                  cnt_areset_n,
    output logic                  cnt_aset_n,
    output logic                  cnt_load_n,
    output logic [countWidth-1:0] cnt_preld,
    output logic                  cnt_updown_n,
    output logic                  cnt_wrapstop_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [countWidth-1:0] MAX_VAL  = '1;
    localparam logic [countWidth-1:0] ZERO_VAL = '0;
    localparam logic [countWidth-1:0] ONE_VAL  = {{(countWidth-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_n;
    logic [1:0]              op_q;
    logic [countWidth-1:0]   data_q;
    logic                    wrap_q;
    logic                    id_q;
    logic [countWidth-1:0]   rem;
    logic [countWidth-1:0]   rem_d;
    logic [countWidth-1:0]   hold_q;
    logic [countWidth-1:0]   hold_d;
    logic                    ovf_q;
    logic                    ovf_d;
`ifndef CNT_SCHED_FIXED_PRIO_EN
    logic                    rr_last;
`endif

    logic                    grant;
    logic                    pick;
    logic [1:0]              sel_op;
    logic [countWidth-1:0]   sel_data;
    logic                    sel_wrap;
    logic                    sel_is_step;

    // Arbitration is only meaningful in IDLE and is suppressed during reset.
    always_comb begin
        grant = 1'b0;
        pick  = 1'b0;
        if (state == S_IDLE && !reset) begin
`ifdef CNT_SCHED_FIXED_PRIO_EN
            if (req0) begin
                grant = 1'b1;
                pick  = 1'b0;
            end else if (req1) begin
                grant = 1'b1;
                pick  = 1'b1;
            end
`else
            if (req0 && req1) begin
                grant = 1'b1;
                pick  = ~rr_last;
            end else if (req0) begin
                grant = 1'b1;
                pick  = 1'b0;
            end else if (req1) begin
                grant = 1'b1;
                pick  = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        sel_op      = pick ? op1   : op0;
        sel_data    = pick ? data1 : data0;
        sel_wrap    = pick ? wrap1 : wrap0;
        sel_is_step = (sel_op == OP_UP) || (sel_op == OP_DOWN);
    end

    assign gnt0 = grant & ~pick;
    assign gnt1 = grant & pick;
    assign busy = (state != S_IDLE) && !reset;
    assign cnt_aset_n = 1'b1;

    // Next-state, datapath shadow and counter pin sequencing.
    always_comb begin
        state_n        = state;
        hold_d         = hold_q;
        ovf_d          = ovf_q;
        rem_d          = rem;
        cnt_load_n     = 1'b0;
        cnt_preld      = hold_q;
        cnt_areset_n   = !reset;
        cnt_updown_n   = 1'b0;
        cnt_wrapstop_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    ovf_d = 1'b0;
                    rem_d = sel_is_step ? sel_data : ONE_VAL;
                    if (sel_is_step && sel_data == ZERO_VAL) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_RUN;
                    end
                end
            end
            S_RUN: begin
                case (op_q)
                    OP_LOAD: begin
                        cnt_load_n = 1'b0;
                        cnt_preld  = data_q;
                        hold_d     = data_q;
                    end
                    OP_CLEAR: begin
                        cnt_areset_n = 1'b0;
                        hold_d       = ZERO_VAL;
                    end
                    OP_UP: begin
                        cnt_load_n     = 1'b1;
                        cnt_updown_n   = 1'b0;
                        cnt_wrapstop_n = ~wrap_q;
                        if (hold_q == MAX_VAL) begin
                            ovf_d  = 1'b1;
                            hold_d = wrap_q ? ZERO_VAL : MAX_VAL;
                        end else begin
                            hold_d = hold_q + ONE_VAL;
                        end
                    end
                    default: begin
                        cnt_load_n     = 1'b1;
                        cnt_updown_n   = 1'b1;
                        cnt_wrapstop_n = ~wrap_q;
                        if (hold_q == ZERO_VAL) begin
                            ovf_d  = 1'b1;
                            hold_d = wrap_q ? MAX_VAL : ZERO_VAL;
                        end else begin
                            hold_d = hold_q - ONE_VAL;
                        end
                    end
                endcase
                rem_d = rem - ONE_VAL;
                if (rem == ONE_VAL) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= OP_LOAD;
            data_q     <= ZERO_VAL;
            wrap_q     <= 1'b0;
            id_q       <= 1'b0;
            rem        <= ZERO_VAL;
            hold_q     <= ZERO_VAL;
            ovf_q      <= 1'b0;
`ifndef CNT_SCHED_FIXED_PRIO_EN
            rr_last    <= 1'b1;
`endif
            done       <= 1'b0;
            done_id    <= 1'b0;
            done_value <= ZERO_VAL;
            done_ovf   <= 1'b0;
        end else begin
            state  <= state_n;
            hold_q <= hold_d;
            ovf_q  <= ovf_d;
            rem    <= rem_d;
            if (grant) begin
                op_q   <= sel_op;
                data_q <= sel_data;
                wrap_q <= sel_wrap;
                id_q   <= pick;
`ifndef CNT_SCHED_FIXED_PRIO_EN
                rr_last <= pick;
`endif
            end
            // Completion results are captured on entry to DONE and then held.
            done <= (state_n == S_DONE);
            if (state_n == S_DONE) begin
                done_id    <= grant ? pick : id_q;
                done_value <= hold_d;
                done_ovf   <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_counter8_cmd_sched.sv
// Randomized scoreboard bench for counter8_cmd_sched with a command-level reference model.
`timescale 1ns/1ps
module tb_counter8_cmd_sched;

    localparam int W = 8;
    localparam int MAXV = (1 << W) - 1;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = '0, op1 = '0;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic wrap0 = 1'b0, wrap1 = 1'b0;
    logic gnt0, gnt1, busy, done, done_id, done_ovf;
    logic [W-1:0] done_value, cnt_preld;
    logic cnt_areset_n, cnt_aset_n, cnt_load_n, cnt_updown_n, cnt_wrapstop_n;

    counter8_cmd_sched #(.countWidth(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .data0(data0), .wrap0(wrap0),
        .req1(req1), .op1(op1), .data1(data1), .wrap1(wrap1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
        .done_value(done_value), .done_ovf(done_ovf),
        .cnt_areset_n(cnt_areset_n), .cnt_aset_n(cnt_aset_n), .cnt_load_n(cnt_load_n),
        .cnt_preld(cnt_preld), .cnt_updown_n(cnt_updown_n), .cnt_wrapstop_n(cnt_wrapstop_n)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic         id;
        logic         ovf;
        logic [W-1:0] value;
        int unsigned  at;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s cyc=%0d got=timeout want=event", name, cyc);
    endtask

    // Command-level result: final value, overflow flag and RUN length.
    task automatic model(input logic [1:0] op, input int d, input bit wrap, input int v,
                         output int nv, output bit ov, output int k);
        int s;
        case (op)
            OP_LOAD:  begin nv = d; ov = 1'b0; k = 1; end
            OP_CLEAR: begin nv = 0; ov = 1'b0; k = 1; end
            OP_UP: begin
                k = d;
                s = v + d;
                ov = (s > MAXV);
                nv = wrap ? (s % (MAXV + 1)) : ((s > MAXV) ? MAXV : s);
            end
            default: begin
                k = d;
                ov = (d > v);
                nv = wrap ? ((v - d + MAXV + 1) % (MAXV + 1)) : ((d > v) ? 0 : v - d);
            end
        endcase
    endtask

    // Grant, busy and counter-pin monitor; pushes expected completions.
    int unsigned next_free = 0;
    bit last_id = 1'b1;
    bit act_valid = 1'b0;
    int unsigned act_t = 0, act_k = 0;
    logic [1:0] act_op = '0;
    logic [W-1:0] act_data = '0;
    bit act_wrap = 1'b0;
    int frozen = 0;
    int pend_val = 0;

    initial begin
        bit run, dcyc, idle, win, eg0, eg1, ov;
        int nv, k;
        exp_t e;
        forever begin
            @(negedge clk);
            chk("aset_n", cnt_aset_n, 1);
            if (reset) begin
                chk("rst_areset_n", cnt_areset_n, 0);
                chk("rst_busy", busy, 0);
                chk("rst_gnt", {gnt0, gnt1}, 0);
                act_valid = 1'b0;
                frozen = 0;
                last_id = 1'b1;
                next_free = cyc + 1;
            end else begin
                run  = act_valid && cyc > act_t && cyc <= act_t + act_k;
                dcyc = act_valid && cyc == act_t + act_k + 1;
                if (dcyc) frozen = pend_val;
                chk("busy", busy, run || dcyc);
                if (run) begin
                    case (act_op)
                        OP_LOAD: begin
                            chk("run_load_n", cnt_load_n, 0);
                            chk("run_preld", cnt_preld, act_data);
                            chk("run_areset_n", cnt_areset_n, 1);
                        end
                        OP_CLEAR: chk("run_clear_areset_n", cnt_areset_n, 0);
                        default: begin
                            chk("run_step_load_n", cnt_load_n, 1);
                            chk("run_updown_n", cnt_updown_n, act_op == OP_DOWN);
                            chk("run_wrapstop_n", cnt_wrapstop_n, !act_wrap);
                            chk("run_step_areset_n", cnt_areset_n, 1);
                        end
                    endcase
                end else begin
                    chk("frz_load_n", cnt_load_n, 0);
                    chk("frz_preld", cnt_preld, frozen);
                    chk("frz_areset_n", cnt_areset_n, 1);
                end
                if (dcyc) act_valid = 1'b0;
                idle = (cyc >= next_free);
`ifdef CNT_SCHED_FIXED_PRIO_EN
                win = 1'b0;
`else
                win = !last_id;
`endif
                eg0 = idle && req0 && (!req1 || win == 1'b0);
                eg1 = idle && req1 && (!req0 || win == 1'b1);
                chk("gnt", {gnt0, gnt1}, {eg0, eg1});
                if (eg0 || eg1) begin
                    act_op   = eg1 ? op1 : op0;
                    act_data = eg1 ? data1 : data0;
                    act_wrap = eg1 ? wrap1 : wrap0;
                    model(act_op, int'(act_data), act_wrap, frozen, nv, ov, k);
                    act_valid = 1'b1;
                    act_t = cyc;
                    act_k = k;
                    pend_val = nv;
                    last_id = eg1;
                    next_free = cyc + k + 2;
                    e.id = eg1;
                    e.ovf = ov;
                    e.value = nv[W-1:0];
                    e.at = cyc + k + 1;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Completion monitor: pops and compares on every done pulse, checks holding otherwise.
    initial begin
        exp_t e;
        logic last_did = 1'b0, last_dov = 1'b0;
        logic [W-1:0] last_dv = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                last_did = 1'b0;
                last_dov = 1'b0;
                last_dv = '0;
                chk("rst_done", done, 0);
            end else if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.at);
                    chk("done_id", done_id, e.id);
                    chk("done_value", done_value, e.value);
                    chk("done_ovf", done_ovf, e.ovf);
                    last_did = e.id;
                    last_dov = e.ovf;
                    last_dv = e.value;
                end
            end else begin
                chk("done_low", done, 0);
                chk("done_hold", {done_id, done_ovf, done_value}, {last_did, last_dov, last_dv});
            end
        end
    end

    task automatic set_req(input bit id, input logic [1:0] op, input logic [W-1:0] d, input bit w);
        if (id) begin req1 = 1'b1; op1 = op; data1 = d; wrap1 = w; end
        else    begin req0 = 1'b1; op0 = op; data0 = d; wrap0 = w; end
    endtask

    task automatic rand_req(input bit id);
        logic [1:0] op;
        logic [W-1:0] d;
        op = 2'($urandom_range(0, 3));
        if (op == OP_LOAD)
            d = ($urandom_range(0, 1) == 1) ? W'($urandom_range(MAXV - 3, MAXV)) : W'($urandom_range(0, MAXV));
        else if ($urandom_range(0, 9) == 0)
            d = W'($urandom_range(200, MAXV));
        else
            d = W'($urandom_range(0, 6));
        set_req(id, op, d, 1'($urandom_range(0, 1)));
    endtask

    task automatic issue(input bit id, input logic [1:0] op, input logic [W-1:0] d, input bit w);
        bit g;
        set_req(id, op, d, w);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            g = id ? gnt1 : gnt0;
            @(posedge clk);
            #1;
            if (g) begin
                if (id) req1 = 1'b0; else req0 = 1'b0;
                return;
            end
        end
        timeout_fail("gnt_wait");
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic stream(input int n0, input int n1);
        int left0, left1, guard;
        bit g0, g1;
        left0 = n0;
        left1 = n1;
        guard = 0;
        if (left0 > 0) rand_req(1'b0);
        if (left1 > 0) rand_req(1'b1);
        while ((req0 || req1) && guard < 8000) begin
            @(negedge clk);
            g0 = gnt0;
            g1 = gnt1;
            @(posedge clk);
            #1;
            guard++;
            if (g0) begin left0--; if (left0 > 0) rand_req(1'b0); else req0 = 1'b0; end
            if (g1) begin left1--; if (left1 > 0) rand_req(1'b1); else req1 = 1'b0; end
        end
        if (req0 || req1) timeout_fail("stream_wait");
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        issue(1'b0, OP_LOAD, 8'h5A, 1'b0);
        issue(1'b0, OP_LOAD, 8'hFE, 1'b0);
        issue(1'b1, OP_UP, 8'd3, 1'b1);
        issue(1'b0, OP_LOAD, 8'h02, 1'b0);
        issue(1'b0, OP_DOWN, 8'd5, 1'b0);
        issue(1'b1, OP_UP, 8'd0, 1'b0);
        issue(1'b1, OP_CLEAR, 8'h33, 1'b1);
        issue(1'b0, OP_DOWN, 8'd1, 1'b1);
        issue(1'b1, OP_UP, 8'd2, 1'b0);
        stream(4, 4);

        issue(1'b0, OP_LOAD, 8'h10, 1'b0);
        issue(1'b0, OP_UP, 8'd10, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        issue(1'b0, OP_UP, 8'd0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rand_req(1'($urandom_range(0, 1)));
            if (req0) issue(1'b0, op0, data0, wrap0);
            else      issue(1'b1, op1, data1, wrap1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        stream(10, 10);

        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter8_cmd_sched.md
Name: counter8_cmd_sched

Overview:
- Command scheduler that shares one counter8uni2 datapath between two requesters.
- Each requester issues one command (load, count up N, count down N, clear); the block arbitrates, sequences the counter's control inputs for the required cycles, then reports completion.
- Between commands it freezes the counter by continuously reloading the last known value.
- Sits directly above counter8uni2 and drives all of its control pins.

Parameters:
- countWidth, 8, width of counter value, load data and step count.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 command request (level, held until gnt0).
- op0  input  2  requester 0 opcode: 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
- data0  input  countWidth  requester 0 load value (LOAD) or step count N (UP/DOWN).
- wrap0  input  1  requester 0 mode: 1 wrap-around, 0 stop/saturate.
- req1, op1, data1, wrap1  input  1/2/countWidth/1  requester 1, same meaning.
- gnt0, gnt1  output  1  one-cycle command accept pulse.
- busy  output  1  high from accept cycle+1 through done cycle.
- done  output  1  one-cycle completion pulse.
- done_id  output  1  requester whose command completed.
- done_value  output  countWidth  counter value after the command.
- done_ovf  output  1  command wrapped or saturated.
- cnt_areset_n  output  1  to counter _areset.
- cnt_aset_n  output  1  to counter _aset (always 1 in this block).
- cnt_load_n  output  1  to counter _load.
- cnt_preld  output  countWidth  to counter preld_val.
- cnt_updown_n  output  1  to counter _updown: 0 up, 1 down.
- cnt_wrapstop_n  output  1  to counter _wrapstop: 0 wrap, 1 stop.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Registers: state, op_q, data_q, wrap_q, id_q, rem (countWidth), hold_q (countWidth), ovf_q, rr_last.

Reset (sync, reset high):
- state=IDLE, hold_q=0, rem=0, ovf_q=0, rr_last=1 (so req0 wins first).
- gnt*=0, done=0, done_id=0, done_value=0, done_ovf=0, busy=0.
- While reset is high, cnt_areset_n=0 combinationally.
- Reset mid-RUN aborts the command; no done pulse is issued.

IDLE:
- Arbitrate among asserted reqs; equal round-robin, granting the requester not in rr_last when both request.
- On grant: pulse gnt for that cycle; latch op/data/wrap/id; set rr_last=id; clear ovf_q.
- rem = data for UP/DOWN, 1 for LOAD/CLEAR.
- Next state: UP/DOWN with data==0 goes to DONE; everything else goes to RUN.

RUN (one cycle per step):
- LOAD: cnt_load_n=0, cnt_preld=data_q; hold_q<=data_q.
- CLEAR: cnt_areset_n=0; hold_q<=0.
- UP/DOWN: cnt_load_n=1, cnt_updown_n per op, cnt_wrapstop_n=~wrap_q; hold_q<=hold_q±1.
  - Wrap mode: modulo 2^countWidth; ovf_q set on 255->0 (up) or 0->255 (down).
  - Stop mode: saturates at max (up) or 0 (down); ovf_q set when a step is blocked.
- rem decrements each cycle; exit to DONE when rem==1.

DONE:
- done=1 with done_id=id_q, done_value=hold_q, done_ovf=ovf_q.
- Next state: IDLE.

Outside RUN (IDLE, DONE):
- Freeze the counter: cnt_load_n=0, cnt_preld=hold_q, cnt_areset_n=1.

General:
- cnt_aset_n is always 1.
- Latency: gnt at cycle t, done at t+k+1 (k=1 for LOAD/CLEAR, k=N for UP/DOWN, k=0 for N==0). Next accept is possible at t+k+2.
- A req deasserted before grant is dropped silently.
- Requests arriving while not in IDLE wait.
- done_* outputs hold their values until the next done pulse.

Optional Feature:
- Macro CNT_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, req0 always beats req1; rr_last is not used.
- Undefined: round-robin as above.

Test Plan:
- Reset then req0 LOAD data=0x5A -> gnt0 at t; cnt_load_n=0/cnt_preld=0x5A at t+1; done at t+2 with done_value=0x5A, done_ovf=0.
- After LOAD 0xFE, req1 UP N=3 wrap=1 -> 3 RUN cycles with cnt_updown_n=0, cnt_wrapstop_n=0; done_value=0x01, done_ovf=1.
- After LOAD 0x02, DOWN N=5 wrap=0 -> done_value=0x00, done_ovf=1, cnt_wrapstop_n=1 during RUN.
- req0 and req1 asserted together repeatedly -> grants alternate 0,1,0,1. With CNT_SCHED_FIXED_PRIO_EN: always gnt0 while req0 is high.
- UP N=0 -> gnt then done the next cycle; no RUN cycle; cnt_load_n stays 0; done_value unchanged.
- reset asserted in the 2nd RUN cycle of UP N=10 -> no done pulse, busy=0, cnt_areset_n=0 during reset; hold_q=0 afterwards.
